// File: rtl/recovery_ctrl.sv
// rtl/recovery_ctrl.sv - exception recovery sequencer: flush, drain, SRAT restore from ARAT, resume
module recovery_ctrl #(
    parameter int NUM_AREG = 8,
    parameter int PREG_W   = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       RegWr_x,
    input  logic                       RegWr_y,
    input  logic                       RegWr_z,
    input  logic                       exp_x,
    input  logic                       exp_y,
    input  logic                       exp_z,
    input  logic                       exec_idle,
    input  logic [NUM_AREG*PREG_W-1:0] ARAT_P_list,
    output logic                       flush,
    output logic                       freeze_front,
    output logic                       freeze_back,
    output logic                       srat_wr_en,
    output logic [2:0]                 srat_wr_addr,
    output logic [PREG_W-1:0]          srat_wr_data,
    output logic [1:0]                 exp_slot,
    output logic                       busy,
    output logic [7:0]                 exp_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FLUSH   = 3'd1,
        ST_DRAIN   = 3'd2,
        ST_RESTORE = 3'd3,
        ST_RESUME  = 3'd4
    } state_t;

    localparam logic [2:0] LAST_ADDR = 3'(NUM_AREG - 1);

    state_t                     state;
    state_t                     state_nxt;
    logic [2:0]                 idx;
    logic [NUM_AREG*PREG_W-1:0] snap;
    logic                       hit_x;
    logic                       hit_y;
    logic                       hit_z;
    logic                       accept;
    logic                       capture;

    assign hit_x = RegWr_x & exp_x;
    assign hit_y = RegWr_y & exp_y;
    assign hit_z = RegWr_z & exp_z;

    // Next-state decode; exceptions are only looked at while idle
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        capture   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (hit_x | hit_y | hit_z) begin
                    accept    = 1'b1;
                    state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (exec_idle) begin
                    capture   = 1'b1;
                    state_nxt = ST_RESTORE;
                end
            end
            ST_RESTORE: begin
                if (idx == LAST_ADDR) begin
                    state_nxt = ST_RESUME;
                end
            end
            ST_RESUME: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Restore address counter; returns to 0 after the last write
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx <= 3'd0;
        end else if (state == ST_RESTORE) begin
            if (idx == LAST_ADDR) begin
                idx <= 3'd0;
            end else begin
                idx <= idx + 3'd1;
            end
        end
    end

    // Snapshot of the committed map, taken once when the back end has drained
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            snap <= '0;
        end else if (capture) begin
            snap <= ARAT_P_list;
        end
    end

    // Exception slot (x has priority) and saturating accept counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exp_slot <= 2'd0;
            exp_cnt  <= 8'd0;
        end else if (accept) begin
            if (hit_x) begin
                exp_slot <= 2'd0;
            end else if (hit_y) begin
                exp_slot <= 2'd1;
            end else begin
                exp_slot <= 2'd2;
            end
            if (exp_cnt != 8'hFF) begin
                exp_cnt <= exp_cnt + 8'd1;
            end
        end
    end

    // Moore outputs decoded from the current state only
    always_comb begin
        flush        = 1'b0;
        freeze_front = 1'b0;
        freeze_back  = 1'b0;
        srat_wr_en   = 1'b0;
        srat_wr_addr = 3'd0;
        srat_wr_data = '0;
        busy         = (state != ST_IDLE);
        case (state)
            ST_FLUSH: begin
                flush        = 1'b1;
                freeze_front = 1'b1;
                freeze_back  = 1'b1;
            end
            ST_DRAIN: begin
                freeze_front = 1'b1;
                freeze_back  = 1'b1;
            end
            ST_RESTORE: begin
                freeze_front = 1'b1;
                freeze_back  = 1'b1;
                srat_wr_en   = 1'b1;
                srat_wr_addr = idx;
                srat_wr_data = snap[int'(idx)*PREG_W +: PREG_W];
            end
            ST_RESUME: begin
                freeze_front = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/recovery_ctrl.md
RECOVERY_CTRL -- requirements
Module: recovery_ctrl

Interface
REQ-001 SHALL have parameter NUM_AREG, default 8: number of architectural registers restored.
REQ-002 SHALL have parameter PREG_W, default 5: physical register tag width.
REQ-003 SHALL have port clk  input  1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1: reset, asynchronous and active-low.
REQ-005 SHALL have ports RegWr_x/RegWr_y/RegWr_z  input  1 each: the retiring instruction in slot x/y/z is valid; x is oldest.
REQ-006 SHALL have ports exp_x/exp_y/exp_z  input  1 each: the retiring instruction in the slot raised an exception.
REQ-007 SHALL have port exec_idle  input  1: no instruction is in flight in the FUs or result broadcast.
REQ-008 SHALL have port ARAT_P_list  input  NUM_AREG x PREG_W: committed architectural-to-physical map.
REQ-009 SHALL have port flush  output  1: single-cycle pipeline flush pulse.
REQ-010 SHALL have ports freeze_front/freeze_back  output  1 each: stall the front end / back end.
REQ-011 SHALL have ports srat_wr_en  output  1, srat_wr_addr  output  3, srat_wr_data  output  PREG_W: SRAT restore write port.
REQ-012 SHALL have port exp_slot  output  2: slot of the accepted exception (0=x, 1=y, 2=z), held until the next accept.
REQ-013 SHALL have port busy  output  1: FSM is not in IDLE.
REQ-014 SHALL have port exp_cnt  output  8: count of accepted exceptions.

Function
REQ-015 SHALL implement the states IDLE, FLUSH, DRAIN, RESTORE and RESUME.
REQ-016 SHALL compute hit_s = RegWr_s & exp_s for each slot s.
REQ-017 SHALL accept an exception when any hit_s is 1 while in IDLE.
REQ-018 SHALL, on accept, go to FLUSH and set exp_slot to the lowest-index hit slot (priority x > y > z).
REQ-019 SHALL ignore exception inputs in every state other than IDLE.
REQ-020 SHALL, in FLUSH, assert flush=1 for exactly one cycle, then go to DRAIN unconditionally.
REQ-021 SHALL remain in DRAIN while exec_idle=0, with no timeout.
REQ-022 SHALL, on the first DRAIN cycle with exec_idle=1, capture ARAT_P_list into an internal snapshot and go to RESTORE.
REQ-023 SHALL, in RESTORE, hold srat_wr_en=1 for exactly NUM_AREG consecutive cycles.
REQ-024 SHALL, in RESTORE, step srat_wr_addr 0,1,...,NUM_AREG-1, with srat_wr_data = snapshot[srat_wr_addr].
REQ-025 SHALL ensure later changes on ARAT_P_list do not affect the restore data.
REQ-026 SHALL go from RESTORE to RESUME after the write to address NUM_AREG-1; the address counter SHALL wrap to 0.
REQ-027 SHALL spend exactly one cycle in RESUME, then go to IDLE.
REQ-028 SHALL drive freeze_back=1 in FLUSH, DRAIN and RESTORE, and 0 in RESUME and IDLE.
REQ-029 SHALL drive freeze_front=1 in FLUSH, DRAIN, RESTORE and RESUME, and 0 in IDLE.
REQ-030 SHALL keep outputs registered: flush, freeze_front, freeze_back and the SRAT port SHALL be Moore outputs of the current state.
REQ-031 SHALL drive srat_wr_en=0, srat_wr_addr=0 and srat_wr_data=0 in all states except RESTORE.
REQ-032 SHALL drive busy=1 in every non-IDLE state.
REQ-033 SHALL increment exp_cnt by 1 on each accept and saturate at 255 (no wrap).
REQ-034 SHALL give minimum accept-to-IDLE latency of 1 (FLUSH) + 1 (DRAIN) + NUM_AREG (RESTORE) + 1 (RESUME) = 11 cycles at default.
REQ-035 SHALL, on an exception coincident with the RESUME to IDLE transition, not accept it; it is accepted only if still presented while in IDLE.

Reset
REQ-036 SHALL, on rst=0 at any time and without waiting for clk, force IDLE.
REQ-037 SHALL, on reset, set flush=0, freeze_front=0, freeze_back=0, srat_wr_en=0, srat_wr_addr=0 and srat_wr_data=0.
REQ-038 SHALL, on reset, set exp_slot=0, busy=0, exp_cnt=0 and the snapshot to all zero.
REQ-039 SHALL abandon any partial restore on reset mid-RESTORE; no further SRAT writes occur after reset release.

Verification
REQ-040 SHALL cover: RegWr_y=1, exp_y=1, exec_idle=1, ARAT[i]=i+8 -> exp_slot=1; flush high one cycle; 8 writes addr 0..7, data 8..15; IDLE 11 cycles after accept; exp_cnt=1.
REQ-041 SHALL cover: hit on x and z in the same cycle -> exp_slot=0; exp_y=1 with RegWr_y=0 -> no accept, busy stays 0.
REQ-042 SHALL cover: exec_idle held 0 for 5 cycles in DRAIN -> freezes stay 1, no SRAT write; ARAT changed after the capture cycle -> written data equals the captured values.
REQ-043 SHALL cover: new exception pulsed during DRAIN and RESTORE -> ignored, exp_cnt unchanged, single restore sequence.
REQ-044 SHALL cover: rst=0 asserted at the 4th RESTORE write -> all outputs zero immediately, IDLE after release, no further writes.
REQ-045 SHALL cover: 260 back-to-back accepted exceptions -> exp_cnt=255.
